// File: rtl/wb_ram_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ram_tester_pkg
//  Description : Shared types and constants for the Wishbone RAM tester:
//                FSM state encoding, Wishbone cycle-type identifiers and the
//                32-bit Galois LFSR polynomial with its step function.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_ram_tester_pkg;

  // Tester sequencing states (explicit 3-bit encoding).
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Wishbone registered-feedback cycle type identifiers.
  localparam logic [2:0]  CTI_CLASSIC        = 3'b000;
  localparam logic [2:0]  CTI_INCR           = 3'b010;
  localparam logic [2:0]  CTI_EOB            = 3'b111;

  // Galois feedback mask applied when the bit shifted out is 1.
  localparam logic [31:0] LFSR_TAPS          = 32'h0040_0007;

  // An all-zero seed would lock the LFSR at zero, so it is replaced.
  localparam logic [31:0] LFSR_SEED_ZERO_SUB = 32'h0000_0001;

  // One Galois LFSR step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {s[30:0], 1'b0} ^ (s[31] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage : wb_ram_tester_pkg
`default_nettype wire

// File: rtl/wb_lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : wb_lfsr32
//  Description : 32-bit Galois LFSR used as the test-pattern generator.
//                Load has priority over step; a zero seed loads as 1.
//  Ports       : clk_i   - clock
//                rst_i   - synchronous active-high reset
//                load_i  - load state from seed_i (zero substituted)
//                step_i  - advance one LFSR step
//                seed_i  - seed value
//                state_o - current LFSR state (pattern word)
//  Revision    : 1.0  initial release
// ============================================================================
module wb_lfsr32
  import wb_ram_tester_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] seed_i,
  output logic [31:0] state_o
);

  logic [31:0] r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= LFSR_SEED_ZERO_SUB;
    end else if (load_i) begin
      r_state <= (seed_i == 32'h0) ? LFSR_SEED_ZERO_SUB : seed_i;
    end else if (step_i) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state_o = r_state;

endmodule : wb_lfsr32
`default_nettype wire

// File: rtl/wb_ram_tester.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ram_tester
//  Description : Wishbone initiator for memory self-test. On start it writes
//                an LFSR pattern to len words starting at base, leaves one
//                idle bus cycle, re-seeds the LFSR and reads the block back,
//                counting mismatches and capturing the first failing word
//                address. A slave error aborts the run.
//  Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//                start_i               - start pulse (sampled only in IDLE)
//                base_adr_i, len_i     - first word address, word count
//                seed_i                - LFSR seed (0 runs as 1)
//                busy_o, done_o        - run in progress, completion pulse
//                abort_o               - last run ended by wb_err_i
//                err_cnt_o             - saturating mismatch count
//                first_err_adr_o       - word address of first mismatch
//                wb_*                  - Wishbone initiator interface
//  Revision    : 1.0  initial release
// ============================================================================
module wb_ram_tester
  import wb_ram_tester_pkg::*;
#(
  parameter int ADR_WIDTH = 13,
  parameter int LEN_WIDTH = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // control / status
  input  logic                 start_i,
  input  logic [ADR_WIDTH-3:0] base_adr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [31:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 abort_o,
  output logic [15:0]          err_cnt_o,
  output logic [ADR_WIDTH-3:0] first_err_adr_o,
  // Wishbone initiator
  output logic [ADR_WIDTH-3:0] wb_adr_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  output logic                 wb_we_o,
  output logic [3:0]           wb_sel_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic [2:0]           wb_cti_o,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i
);

  localparam int                 WAW        = ADR_WIDTH - 2;
  localparam logic [WAW-1:0]       c_adr_one  = WAW'(1);
  localparam logic [LEN_WIDTH-1:0] c_cnt_one  = LEN_WIDTH'(1);
  localparam logic [15:0]          c_err_max  = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_next;
  logic [WAW-1:0]       r_base;
  logic [WAW-1:0]       r_adr;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic [31:0]          r_seed;
  logic [15:0]          r_err_cnt;
  logic [WAW-1:0]       r_first_err;
  logic                 r_abort;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_in_bus;     // WRITE or READ: a bus cycle is open
  logic        w_err;        // slave error on an open cycle
  logic        w_word_ok;    // word completed normally (error wins over ack)
  logic        w_last;       // current word is the last of the phase
  logic        w_start_run;  // accepted start with a non-empty block
  logic        w_lfsr_load;
  logic [31:0] w_lfsr_seed;
  logic [31:0] w_lfsr;
  logic        w_mismatch;

  assign w_in_bus    = (r_state == WRITE) || (r_state == READ);
  assign w_err       = w_in_bus && wb_err_i;
  assign w_word_ok   = w_in_bus && wb_ack_i && !wb_err_i;
  assign w_last      = (r_cnt == (r_len - c_cnt_one));
  assign w_start_run = (r_state == IDLE) && start_i && (len_i != '0);

  // The LFSR is seeded at start and reloaded from the latched seed in GAP so
  // the read phase regenerates exactly the written sequence.
  assign w_lfsr_load = w_start_run || (r_state == GAP);
  assign w_lfsr_seed = (r_state == IDLE) ? seed_i : r_seed;
  assign w_mismatch  = (r_state == READ) && w_word_ok && (wb_dat_i != w_lfsr);

  wb_lfsr32 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_lfsr_load),
    .step_i  (w_word_ok),
    .seed_i  (w_lfsr_seed),
    .state_o (w_lfsr)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and bus/status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    wb_we_o  = 1'b0;
    wb_sel_o = 4'h0;
    wb_cti_o = CTI_CLASSIC;
    wb_dat_o = 32'h0;
    busy_o   = 1'b0;
    done_o   = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next = (len_i == '0) ? DONE : WRITE;
        end
      end

      WRITE: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_sel_o = 4'hF;
        wb_cti_o = w_last ? CTI_EOB : CTI_INCR;
        wb_dat_o = w_lfsr;
        busy_o   = 1'b1;
        if (w_err) begin
          w_next = DONE;
        end else if (w_word_ok && w_last) begin
          w_next = GAP;
        end
      end

      GAP: begin
        busy_o = 1'b1;
        w_next = READ;
      end

      READ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 4'hF;
        wb_cti_o = w_last ? CTI_EOB : CTI_INCR;
        busy_o   = 1'b1;
        if (w_err || (w_word_ok && w_last)) begin
          w_next = DONE;
        end
      end

      DONE: begin
        done_o = 1'b1;
        w_next = IDLE;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address/word counters, result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base      <= '0;
      r_adr       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_seed      <= 32'h0;
      r_err_cnt   <= 16'h0;
      r_first_err <= '0;
      r_abort     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_base      <= base_adr_i;
            r_adr       <= base_adr_i;
            r_len       <= len_i;
            r_cnt       <= '0;
            r_seed      <= seed_i;
            r_err_cnt   <= 16'h0;
            r_first_err <= '0;
            r_abort     <= 1'b0;
          end
        end

        WRITE, READ: begin
          if (w_err) begin
            r_abort <= 1'b1;
          end else if (w_word_ok) begin
            // At the end of a phase rewind to base for the read pass.
            if (w_last) begin
              r_adr <= r_base;
              r_cnt <= '0;
            end else begin
              r_adr <= r_adr + c_adr_one;
              r_cnt <= r_cnt + c_cnt_one;
            end
          end

          if (w_mismatch) begin
            // Count is cleared at start and saturates, so zero means
            // "no mismatch seen yet in this run".
            if (r_err_cnt == 16'h0) begin
              r_first_err <= r_adr;
            end
            if (r_err_cnt != c_err_max) begin
              r_err_cnt <= r_err_cnt + 16'h1;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign wb_adr_o        = r_adr;
  assign abort_o         = r_abort;
  assign err_cnt_o       = r_err_cnt;
  assign first_err_adr_o = r_first_err;

endmodule : wb_ram_tester
`default_nettype wire

// File: doc/wb_ram_tester.md
Name: wb_ram_tester

Overview:
- Wishbone initiator (master) that exercises a word-addressed Wishbone RAM slave.
- On a start command it writes a pseudo-random LFSR pattern to a block of words, then reads the block back and compares every word.
- It reports an error count and the first failing address.
- Sits in the test/bring-up subsystem, directly or via interconnect in front of the RAM slave; used for memory built-in self-test.

Parameters:
- ADR_WIDTH, 13, byte-address width; bus carries word address bits [ADR_WIDTH-1:2]
- LEN_WIDTH, 11, width of word-count field

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- base_adr_i  in  ADR_WIDTH-2  first word address
- len_i  in  LEN_WIDTH  number of words to test
- seed_i  in  32  LFSR seed; 0 is replaced by 32'h1
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle completion pulse
- abort_o  out  1  last run terminated by wb_err_i; held until next start
- err_cnt_o  out  16  mismatch count, saturating at 16'hFFFF; held until next start
- first_err_adr_o  out  ADR_WIDTH-2  word address of first mismatch; 0 if none
- wb_adr_o  out  ADR_WIDTH-2  word address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_we_o  out  1  write enable
- wb_sel_o  out  4  byte selects; always 4'hF while cyc
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle and strobe; always equal
- wb_cti_o  out  3  3'b010 for every word except the last of a phase; 3'b111 on the last word
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error

Behaviour:
- Reset (rst_i high at clk_i edge), including mid-run:
  - next cycle: state IDLE; cyc/stb/we/busy/done/abort = 0; err_cnt = 0; first_err_adr = 0; adr/dat/cti = 0.
  - No bus cycle may remain open.
- States and transitions:
  - IDLE -> WRITE on start_i with len_i != 0. Latch base, len, seed; clear err_cnt, first_err_adr, abort.
  - IDLE -> DONE on start_i with len_i == 0. No bus activity; err_cnt = 0.
  - WRITE: cyc = stb = we = 1; adr = base + k; dat = LFSR state k.
  - GAP: exactly one cycle with cyc = stb = 0; LFSR reloaded from seed.
  - READ: cyc = stb = 1, we = 0.
  - DONE: done_o = 1 for one cycle, busy_o = 0, then -> IDLE.
- Word advance: on each wb_ack_i, advance adr and LFSR at that edge. stb stays high (no idle cycle between words). The slave's own ack/!ack gating spaces the acks.
- Phase ends: ack of word len-1 in WRITE -> GAP; ack of word len-1 in READ -> DONE.
- Read compare: on each READ ack, compare wb_dat_i with the LFSR value.
  - On mismatch, err_cnt increments (saturating).
  - first_err_adr is captured only on the first mismatch.
- LFSR: Galois 32-bit. next = {s[30:0],1'b0} ^ (s[31] ? 32'h0040_0007 : 0).
- Address arithmetic: wraps modulo 2^(ADR_WIDTH-2).
- wb_err_i with cyc high: terminates the word. Next state DONE, abort_o = 1, cyc drops. err_cnt is held as accumulated so far.
- wb_ack_i or wb_err_i while cyc = 0: ignored.
- start_i while busy: ignored.
- Timing against a slave that acks one cycle after stb and holds ack for one cycle:
  - word k of WRITE is acked at cycle 2k+2 after the start cycle;
  - GAP at cycle 2N+1;
  - done_o at cycle 4N+2.

Decomposition:
- Package wb_ram_tester_pkg:
  - state enum {IDLE, WRITE, GAP, READ, DONE};
  - CTI_INCR = 3'b010, CTI_EOB = 3'b111;
  - LFSR_TAPS = 32'h0040_0007;
  - LFSR_SEED_ZERO_SUB = 32'h1.
- One sub-module, wb_lfsr32 (load, step, seed, state).
- FSM, counters and Wishbone drive stay in the top module.

Test Plan:
- Real RAM slave, base = 0x10, len = 4, seed = 0xACE1 -> four writes to 0x10..0x13 with LFSR values, cti 010,010,010,111; done_o at cycle 18; err_cnt = 0; abort = 0.
- Same run, with the bench corrupting wb_dat_i bit 0 on read words 1 and 3 -> err_cnt = 2, first_err_adr = 0x11.
- len = 0, start -> done_o next cycle; cyc never asserted; err_cnt = 0.
- base = 0x7FE (ADR_WIDTH = 13), len = 4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001; no errors.
- Slave asserts wb_err_i on the second write -> cyc drops the following cycle, done_o pulses, abort_o = 1, no READ phase.
- rst_i asserted during READ word 2 -> next cycle cyc = 0, busy = 0, err_cnt = 0; a new start with seed = 0 runs with seed 0x1 and passes.
